// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Sequences a control-flow redirect once the EX-stage comparator resolves a
// taken branch, JAL or JALR. It captures the target, holds the redirect
// request until fetch accepts it, and then keeps the IF/ID and ID/EX flushes
// asserted for a programmable tail. Branch inputs arriving while a redirect
// is in flight belong to the wrong path and are ignored.
//
// Optional build macro: BRANCH_STATS_EN
//   defined     - taken/not-taken counters that saturate at all-ones
//   not defined - taken_cnt/not_taken_cnt are tied to zero and no counter
//                 flops are built
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a taken branch; capture and statistics active
// REDIRECT | redirect_valid and both flushes held until fetch_ready
// FLUSH    | flushes held for FLUSH_CYCLES cycles after the accept

module branch_redirect_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h00400004,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic [3:0]       ex_br,
   input  logic             br_success,
   input  logic [31:0]      br_target,
   input  logic             stall,
   input  logic             fetch_ready,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             busy,
   output logic             misalign_err,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] not_taken_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   localparam logic [3:0] BR_NONE = 4'd0;
   localparam logic [3:0] BR_BGEU = 4'd6;
   localparam logic [3:0] BR_JAL  = 4'd7;
   localparam logic [3:0] BR_JALR = 4'd8;

   // Tail length is 0..7, so a 3-bit down-counter covers every legal value.
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

   state_t      state_q, state_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        flush_q, flush_d;
   logic        misalign_q, misalign_d;
   logic [2:0]  flush_cnt_q, flush_cnt_d;

   logic        is_branch;
   logic        is_jalr;
   logic        capture;
   logic [31:0] tgt;
   logic        tgt_misaligned;

   // Codes above JALR are not branches at all.
   assign is_branch = (ex_br != BR_NONE) && (ex_br <= BR_JALR);
   assign is_jalr   = (ex_br == BR_JALR);

   // Capture qualifier; it is only acted on in IDLE, which is what drops
   // wrong-path branches seen while a redirect is in flight.
   assign capture = ex_valid && is_branch && br_success && !stall;

   // JALR clears bit 0 of its target; bit 1 set means a misaligned target.
   assign tgt            = {br_target[31:1], br_target[0] & ~is_jalr};
   assign tgt_misaligned = tgt[1];

   // State and output registers; reset drops any pending redirect.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= RESET_PC;
         flush_q          <= 1'b0;
         misalign_q       <= 1'b0;
         flush_cnt_q      <= 3'd0;
      end else begin
         state_q          <= state_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         flush_q          <= flush_d;
         misalign_q       <= misalign_d;
         flush_cnt_q      <= flush_cnt_d;
      end
   end

   // Next-state and next-output logic; misalign_err is a one-cycle pulse.
   always_comb begin
      state_d          = state_q;
      redirect_valid_d = redirect_valid_q;
      redirect_pc_d    = redirect_pc_q;
      flush_d          = flush_q;
      misalign_d       = 1'b0;
      flush_cnt_d      = flush_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (capture) begin
               if (tgt_misaligned) begin
                  misalign_d = 1'b1;
               end else begin
                  redirect_pc_d    = tgt;
                  redirect_valid_d = 1'b1;
                  flush_d          = 1'b1;
                  state_d          = REDIRECT;
               end
            end
         end

         REDIRECT: begin
            // No timeout: the request is held until fetch takes it.
            if (redirect_valid_q && fetch_ready) begin
               redirect_valid_d = 1'b0;
               if (FLUSH_CYCLES == 0) begin
                  flush_d = 1'b0;
                  state_d = IDLE;
               end else begin
                  flush_cnt_d = FLUSH_LOAD;
                  state_d     = FLUSH;
               end
            end
         end

         FLUSH: begin
            if (flush_cnt_q <= 3'd1) begin
               flush_cnt_d = 3'd0;
               flush_d     = 1'b0;
               state_d     = IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end

         default: begin
            state_d          = IDLE;
            redirect_valid_d = 1'b0;
            flush_d          = 1'b0;
            flush_cnt_d      = 3'd0;
         end
      endcase
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign flush_ifid     = flush_q;
   assign flush_idex     = flush_q;
   assign misalign_err   = misalign_q;
   assign busy           = (state_q != IDLE);

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] taken_q;
   logic [CNT_W-1:0] not_taken_q;
   logic             count_en;
   logic             is_cond;
   logic             is_jump;
   logic             inc_taken;
   logic             inc_not_taken;

   // Statistics share the capture window: IDLE, unstalled, valid.
   // Misaligned targets still count as taken.
   always_comb begin
      count_en      = (state_q == IDLE) && ex_valid && !stall;
      is_cond       = (ex_br != BR_NONE) && (ex_br <= BR_BGEU);
      is_jump       = (ex_br == BR_JAL) || (ex_br == BR_JALR);
      inc_taken     = count_en && ((is_cond && br_success) || is_jump);
      inc_not_taken = count_en && is_cond && !br_success;
   end

   // Saturating counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         taken_q     <= '0;
         not_taken_q <= '0;
      end else begin
         if (inc_taken && (taken_q != '1)) begin
            taken_q <= taken_q + CNT_W'(1);
         end
         if (inc_not_taken && (not_taken_q != '1)) begin
            not_taken_q <= not_taken_q + CNT_W'(1);
         end
      end
   end

   assign taken_cnt     = taken_q;
   assign not_taken_cnt = not_taken_q;
`else
   assign taken_cnt     = '0;
   assign not_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the redirect sequence.
module tb_branch_redirect_ctrl;

   localparam logic [31:0] RST_PC = 32'h00400004;
   localparam int          FC     = 1;
   localparam int          CW     = 16;
   localparam int          CMAX   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ex_valid = 1'b0;
   logic [3:0]    ex_br = 4'd0;
   logic          br_success = 1'b0;
   logic [31:0]   br_target = 32'd0;
   logic          stall = 1'b0;
   logic          fetch_ready = 1'b0;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          flush_ifid;
   logic          flush_idex;
   logic          busy;
   logic          misalign_err;
   logic [CW-1:0] taken_cnt;
   logic [CW-1:0] not_taken_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(
      .RESET_PC(RST_PC),
      .FLUSH_CYCLES(FC),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ex_valid(ex_valid),
      .ex_br(ex_br),
      .br_success(br_success),
      .br_target(br_target),
      .stall(stall),
      .fetch_ready(fetch_ready),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .flush_ifid(flush_ifid),
      .flush_idex(flush_idex),
      .busy(busy),
      .misalign_err(misalign_err),
      .taken_cnt(taken_cnt),
      .not_taken_cnt(not_taken_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   // Behavioural model: a redirect is "waiting for accept", then occupies a
   // fixed number of extra flush cycles; branches only matter when neither
   // is pending.
   bit          m_wait;
   int          m_left;
   logic [31:0] m_pc;
   bit          m_mis;
   int          m_tc, m_ntc;

   always @(posedge clk or posedge reset) begin
      logic [31:0] t;
      if (reset) begin
         m_wait = 0; m_left = 0; m_pc = RST_PC; m_mis = 0; m_tc = 0; m_ntc = 0;
      end else begin
         m_mis = 0;
         if (m_wait) begin
            if (fetch_ready) begin
               m_wait = 0;
               m_left = FC;
            end
         end else if (m_left > 0) begin
            m_left = m_left - 1;
         end else if (ex_valid && !stall) begin
            t = br_target;
            if (ex_br == 4'd8) t[0] = 1'b0;
            if (ex_br >= 4'd1 && ex_br <= 4'd8 && br_success) begin
               if (t[1]) m_mis = 1;
               else begin
                  m_pc = t;
                  m_wait = 1;
               end
            end
`ifdef BRANCH_STATS_EN
            if ((ex_br >= 4'd1 && ex_br <= 4'd6 && br_success) || ex_br == 4'd7 || ex_br == 4'd8) begin
               if (m_tc < CMAX) m_tc++;
            end else if (ex_br >= 4'd1 && ex_br <= 4'd6) begin
               if (m_ntc < CMAX) m_ntc++;
            end
`endif
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("redirect_valid", 32'(redirect_valid), 32'(m_wait));
         chk("redirect_pc", redirect_pc, m_pc);
         chk("flush_ifid", 32'(flush_ifid), 32'(m_wait || m_left > 0));
         chk("flush_idex", 32'(flush_idex), 32'(m_wait || m_left > 0));
         chk("busy", 32'(busy), 32'(m_wait || m_left > 0));
         chk("misalign_err", 32'(misalign_err), 32'(m_mis));
         chk("taken_cnt", 32'(taken_cnt), 32'(m_tc));
         chk("not_taken_cnt", 32'(not_taken_cnt), 32'(m_ntc));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] br, input logic s,
                        input logic [31:0] tg, input logic st, input logic fr);
      ex_valid = v; ex_br = br; br_success = s; br_target = tg; stall = st; fetch_ready = fr;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b1);
   endtask

   // Issue one branch for a cycle, then wait (bounded) for the controller to go idle.
   task automatic br_wait(input logic [3:0] br, input logic s, input logic [31:0] tg);
      int n;
      drive(1'b1, br, s, tg, 1'b0, 1'b1);
      step();
      idle();
      n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) chk("br_wait_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset asserted between clock edges: outputs must clear at once.
      #1 reset = 1'b1;
      #2;
      chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'h00400004);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flush_ifid", 32'(flush_ifid), 32'd0);
      chk_en = 1'b1;
      step();
      reset = 1'b0;
      idle();
      step();

      // BEQ taken, fetch ready immediately.
      drive(1'b1, 4'd1, 1'b1, 32'h00400020, 1'b0, 1'b1);
      step();
      idle();
      chk("beq_rv", 32'(redirect_valid), 32'd1);
      chk("beq_pc", redirect_pc, 32'h00400020);
      chk("beq_flush", 32'(flush_idex), 32'd1);
      step();
      chk("beq_rv_drop", 32'(redirect_valid), 32'd0);
      chk("beq_flush_c2", 32'(flush_ifid), 32'd1);
      chk("beq_busy_c2", 32'(busy), 32'd1);
      step();
      chk("beq_flush_c3", 32'(flush_ifid), 32'd0);
      chk("beq_busy_c3", 32'(busy), 32'd0);

      // JALR with odd target, fetch stalls for three cycles.
      drive(1'b1, 4'd8, 1'b1, 32'h00400031, 1'b0, 1'b0);
      step();
      drive(1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      chk("jalr_pc", redirect_pc, 32'h00400030);
      chk("jalr_rv_c1", 32'(redirect_valid), 32'd1);
      step();
      chk("jalr_rv_c2", 32'(redirect_valid), 32'd1);
      step();
      chk("jalr_rv_c3", 32'(redirect_valid), 32'd1);
      step();
      chk("jalr_rv_c4", 32'(redirect_valid), 32'd1);
      fetch_ready = 1'b1;
      step();
      chk("jalr_rv_accepted", 32'(redirect_valid), 32'd0);
      step();
      chk("jalr_idle", 32'(busy), 32'd0);

      // BNE to a misaligned target.
      drive(1'b1, 4'd2, 1'b1, 32'h00400022, 1'b0, 1'b1);
      step();
      idle();
      chk("mis_pulse", 32'(misalign_err), 32'd1);
      chk("mis_no_rv", 32'(redirect_valid), 32'd0);
      chk("mis_busy", 32'(busy), 32'd0);
      chk("mis_pc_kept", redirect_pc, 32'h00400030);
      step();
      chk("mis_pulse_end", 32'(misalign_err), 32'd0);

      // Wrong-path BLT while busy, then a stalled branch.
      drive(1'b1, 4'd1, 1'b1, 32'h00400100, 1'b0, 1'b0);
      step();
      chk("bz_pc1", redirect_pc, 32'h00400100);
      drive(1'b1, 4'd3, 1'b1, 32'h00400200, 1'b0, 1'b1);
      step();
      chk("bz_ignored_pc", redirect_pc, 32'h00400100);
      chk("bz_ignored_rv", 32'(redirect_valid), 32'd0);
      drive(1'b1, 4'd4, 1'b1, 32'h00400300, 1'b1, 1'b1);
      step();
      chk("bz_back_idle", 32'(busy), 32'd0);
      step();
      chk("stall_blocks_rv", 32'(redirect_valid), 32'd0);
      chk("stall_blocks_pc", redirect_pc, 32'h00400100);
      stall = 1'b0;
      step();
      idle();
      chk("stall_release_rv", 32'(redirect_valid), 32'd1);
      chk("stall_release_pc", redirect_pc, 32'h00400300);
      step();
      step();

      // Statistics: 3 taken BGE, 2 not-taken BLTU, 1 JAL from a clean reset.
      #1 reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) br_wait(4'd4, 1'b1, 32'h00400040 + 32'(i * 16));
      for (int i = 0; i < 2; i++) br_wait(4'd5, 1'b0, 32'h00400070);
      br_wait(4'd7, 1'b1, 32'h00400080);
`ifdef BRANCH_STATS_EN
      chk("stats_taken", 32'(taken_cnt), 32'd4);
      chk("stats_not_taken", 32'(not_taken_cnt), 32'd2);
`else
      chk("stats_taken_off", 32'(taken_cnt), 32'd0);
      chk("stats_not_taken_off", 32'(not_taken_cnt), 32'd0);
`endif
      // Reset in the middle of a redirect drops it.
      drive(1'b1, 4'd1, 1'b1, 32'h00400090, 1'b0, 1'b0);
      step();
      idle();
      fetch_ready = 1'b0;
      chk("pre_rst_rv", 32'(redirect_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_rv", 32'(redirect_valid), 32'd0);
      chk("midrst_taken", 32'(taken_cnt), 32'd0);
      chk("midrst_not_taken", 32'(not_taken_cnt), 32'd0);
      chk("midrst_pc", redirect_pc, 32'h00400004);
      chk("midrst_busy", 32'(busy), 32'd0);
      step();
      reset = 1'b0;

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         ex_valid    = ($urandom_range(0, 3) != 0);
         ex_br       = 4'($urandom_range(0, 10));
         br_success  = 1'($urandom_range(0, 1));
         br_target   = 32'h00400000 | ($urandom & 32'h0000fffc);
         if ($urandom_range(0, 3) == 0) br_target = br_target | 32'($urandom_range(0, 3));
         stall       = ($urandom_range(0, 3) == 0);
         fetch_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 299) == 0) begin
            #2 reset = 1'b1;
            step();
            reset = 1'b0;
         end else begin
            step();
         end
      end

      idle();
      step();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
